// File: rtl/sbox_scheduler.sv
// sbox_scheduler
//   Time-shares LANES combinational AES S-boxes between the round datapath
//   (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit
//   word). One request is accepted in IDLE and its bytes are substituted in
//   place, LANES bytes per cycle, in RUN. The result is then held in RESP
//   until the owner's consumer takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   st_req_valid_i/_ready_o, st_in_i[127:0]    state SubBytes request
//   st_rsp_valid_o/st_rsp_ready_i, st_out_o    state result (byte i = [8i+7:8i])
//   kw_req_valid_i/_ready_o, kw_in_i[31:0]     key-word SubWord request
//   kw_rsp_valid_o/kw_rsp_ready_i, kw_out_o    key-word result
//   busy_o                                     FSM not in IDLE
module sbox_scheduler #(
  parameter int unsigned LANES = 4  // 1, 2 or 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid_i,
  output logic         st_req_ready_o,
  input  logic [127:0] st_in_i,
  output logic         st_rsp_valid_o,
  input  logic         st_rsp_ready_i,
  output logic [127:0] st_out_o,
  input  logic         kw_req_valid_i,
  output logic         kw_req_ready_o,
  input  logic [31:0]  kw_in_i,
  output logic         kw_rsp_valid_o,
  input  logic         kw_rsp_ready_i,
  output logic [31:0]  kw_out_o,
  output logic         busy_o
);

  localparam int unsigned NCHUNK = 16 / LANES;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] ST_LAST = CW'(NCHUNK - 1);
  localparam logic [CW-1:0] KW_LAST = CW'(4 / LANES - 1);

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;
  typedef enum logic {REQ_ST = 1'b0, REQ_KW = 1'b1} req_e;

  state_e        state_q, state_d;
  logic [127:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_e          owner_q, owner_d;
  req_e          last_q, last_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      owner_q <= REQ_ST;
      last_q  <= REQ_KW;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    int unsigned idx;
    idx     = 0;
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (st_req_ready_o) begin
          work_d  = st_in_i;
          owner_d = REQ_ST;
          last_d  = REQ_ST;
          cnt_d   = '0;
          state_d = RUN;
        end else if (kw_req_ready_o) begin
          work_d  = {96'b0, kw_in_i};
          owner_d = REQ_KW;
          last_d  = REQ_KW;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          idx = 32'(cnt_q) * LANES + l;
          work_d[idx*8 +: 8] = sbox(work_q[idx*8 +: 8]);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ((owner_q == REQ_KW) ? KW_LAST : ST_LAST))
          state_d = RESP;
      end
      RESP: begin
        if ((owner_q == REQ_ST && st_rsp_ready_i) ||
            (owner_q == REQ_KW && kw_rsp_ready_i))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; on a tie the requester that did not win last time is granted.
  always_comb begin
    st_req_ready_o = (state_q == IDLE) && st_req_valid_i &&
                     (!kw_req_valid_i || last_q == REQ_KW);
    kw_req_ready_o = (state_q == IDLE) && kw_req_valid_i &&
                     (!st_req_valid_i || last_q == REQ_ST);
    st_rsp_valid_o = (state_q == RESP) && (owner_q == REQ_ST);
    kw_rsp_valid_o = (state_q == RESP) && (owner_q == REQ_KW);
    busy_o         = (state_q != IDLE);
    st_out_o       = work_q;
    kw_out_o       = work_q[31:0];
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
module tb_sbox_scheduler;

  localparam logic [127:0] V1  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] E1  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] KV  = 128'hcf4f3c09;
  localparam logic [127:0] KE  = 128'h8a84eb01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Index 0: LANES=4, 1: LANES=2, 2: LANES=1
  logic         st_req_valid [3];
  logic         st_req_ready [3];
  logic [127:0] st_in        [3];
  logic         st_rsp_valid [3];
  logic         st_rsp_ready [3];
  logic [127:0] st_out       [3];
  logic         kw_req_valid [3];
  logic         kw_req_ready [3];
  logic [31:0]  kw_in        [3];
  logic         kw_rsp_valid [3];
  logic         kw_rsp_ready [3];
  logic [31:0]  kw_out       [3];
  logic         busy         [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sbox_scheduler #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid_i(st_req_valid[0]), .st_req_ready_o(st_req_ready[0]), .st_in_i(st_in[0]),
    .st_rsp_valid_o(st_rsp_valid[0]), .st_rsp_ready_i(st_rsp_ready[0]), .st_out_o(st_out[0]),
    .kw_req_valid_i(kw_req_valid[0]), .kw_req_ready_o(kw_req_ready[0]), .kw_in_i(kw_in[0]),
    .kw_rsp_valid_o(kw_rsp_valid[0]), .kw_rsp_ready_i(kw_rsp_ready[0]), .kw_out_o(kw_out[0]),
    .busy_o(busy[0]));

  sbox_scheduler #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid_i(st_req_valid[1]), .st_req_ready_o(st_req_ready[1]), .st_in_i(st_in[1]),
    .st_rsp_valid_o(st_rsp_valid[1]), .st_rsp_ready_i(st_rsp_ready[1]), .st_out_o(st_out[1]),
    .kw_req_valid_i(kw_req_valid[1]), .kw_req_ready_o(kw_req_ready[1]), .kw_in_i(kw_in[1]),
    .kw_rsp_valid_o(kw_rsp_valid[1]), .kw_rsp_ready_i(kw_rsp_ready[1]), .kw_out_o(kw_out[1]),
    .busy_o(busy[1]));

  sbox_scheduler #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid_i(st_req_valid[2]), .st_req_ready_o(st_req_ready[2]), .st_in_i(st_in[2]),
    .st_rsp_valid_o(st_rsp_valid[2]), .st_rsp_ready_i(st_rsp_ready[2]), .st_out_o(st_out[2]),
    .kw_req_valid_i(kw_req_valid[2]), .kw_req_ready_o(kw_req_ready[2]), .kw_in_i(kw_in[2]),
    .kw_rsp_valid_o(kw_rsp_valid[2]), .kw_rsp_ready_i(kw_rsp_ready[2]), .kw_out_o(kw_out[2]),
    .busy_o(busy[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on instance d; lat = posedges from accept to the edge where
  // rsp_valid is first sampled high; hold = cycles of back-pressure.
  task automatic do_req(input int d, input bit kw, input logic [127:0] data,
                        input logic [127:0] exp, input int lat, input int hold);
    int cyc;
    bit seen;
    @(negedge clk);
    if (kw) begin kw_in[d] = data[31:0]; kw_req_valid[d] = 1'b1; end
    else    begin st_in[d] = data;       st_req_valid[d] = 1'b1; end
    #1 check(kw ? "kw_req_ready" : "st_req_ready", kw ? kw_req_ready[d] : st_req_ready[d], 1'b1);
    @(posedge clk);
    #1;
    st_req_valid[d] = 1'b0;
    kw_req_valid[d] = 1'b0;
    st_in[d] = ~data;
    kw_in[d] = ~data[31:0];
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      seen = kw ? kw_rsp_valid[d] : st_rsp_valid[d];
      @(posedge clk);
      cyc++;
    end
    check(kw ? "kw_latency" : "st_latency", 128'(cyc), 128'(lat));
    #1;
    if (kw) check("kw_out", 128'(kw_out[d]), exp);
    else    check("st_out", st_out[d], exp);
    check("other_rsp_valid", kw ? st_rsp_valid[d] : kw_rsp_valid[d], 1'b0);
    check("busy_in_resp", busy[d], 1'b1);
    if (hold > 0) begin
      st_req_valid[d] = 1'b1;
      kw_req_valid[d] = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", kw ? kw_rsp_valid[d] : st_rsp_valid[d], 1'b1);
      if (kw) check("bp_kw_out", 128'(kw_out[d]), exp);
      else    check("bp_st_out", st_out[d], exp);
      check("bp_busy", busy[d], 1'b1);
      check("bp_no_ready", {st_req_ready[d], kw_req_ready[d]}, 2'b00);
    end
    st_req_valid[d] = 1'b0;
    kw_req_valid[d] = 1'b0;
    if (kw) kw_rsp_ready[d] = 1'b1; else st_rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    st_rsp_ready[d] = 1'b0;
    kw_rsp_ready[d] = 1'b0;
    check("idle_after_rsp", busy[d], 1'b0);
    check("rsp_valid_dropped", kw ? kw_rsp_valid[d] : st_rsp_valid[d], 1'b0);
  endtask

  initial begin
    logic [2:0] gr;
    int ng;
    logic sr, kr;

    for (int d = 0; d < 3; d++) begin
      st_req_valid[d] = 1'b0; st_in[d] = '0; st_rsp_ready[d] = 1'b0;
      kw_req_valid[d] = 1'b0; kw_in[d] = '0; kw_rsp_ready[d] = 1'b0;
    end

    // Reset values
    #12;
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", busy[d], 1'b0);
      check("rst_rsp_valid", {st_rsp_valid[d], kw_rsp_valid[d]}, 2'b00);
      check("rst_ready", {st_req_ready[d], kw_req_ready[d]}, 2'b00);
      check("rst_st_out", st_out[d], '0);
      check("rst_kw_out", 128'(kw_out[d]), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Tie arbitration straight after reset: ST, KW, ST
    st_in[0] = V1;
    kw_in[0] = KV[31:0];
    st_rsp_ready[0] = 1'b1;
    kw_rsp_ready[0] = 1'b1;
    @(negedge clk);
    st_req_valid[0] = 1'b1;
    kw_req_valid[0] = 1'b1;
    gr = '0;
    ng = 0;
    for (int i = 0; i < 60 && ng < 3; i++) begin
      #1;
      sr = st_req_ready[0];
      kr = kw_req_ready[0];
      check("tie_single_ready", sr & kr, 1'b0);
      if (busy[0]) check("tie_ready_while_busy", sr | kr, 1'b0);
      if (sr | kr) begin
        gr[ng] = kr;
        ng++;
      end
      if (ng < 3) @(negedge clk);
    end
    check("tie_grant_count", 128'(ng), 128'(3));
    check("tie_grant_order", gr, 3'b010);
    @(posedge clk);
    #1;
    st_req_valid[0] = 1'b0;
    kw_req_valid[0] = 1'b0;
    for (int i = 0; i < 40 && busy[0]; i++) @(negedge clk);
    check("tie_drain_idle", busy[0], 1'b0);
    st_rsp_ready[0] = 1'b0;
    kw_rsp_ready[0] = 1'b0;

    // LANES=4 functional and back-pressure
    do_req(0, 1'b0, V1, E1, 5, 0);
    do_req(0, 1'b1, KV, KE, 2, 0);
    do_req(0, 1'b0, V1, E1, 5, 10);
    do_req(0, 1'b1, KV, KE, 2, 3);

    // Reset during RUN
    @(negedge clk);
    st_in[0] = V1;
    st_req_valid[0] = 1'b1;
    @(posedge clk);
    #1 st_req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("midrun_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_rsp_valid", {st_rsp_valid[0], kw_rsp_valid[0]}, 2'b00);
    check("midrst_ready", {st_req_ready[0], kw_req_ready[0]}, 2'b00);
    check("midrst_st_out", st_out[0], '0);
    check("midrst_kw_out", 128'(kw_out[0]), '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, '0, {16{8'h63}}, 5, 0);

    // Narrower lane counts
    do_req(1, 1'b0, V1, E1, 9, 0);
    do_req(1, 1'b1, KV, KE, 3, 0);
    do_req(2, 1'b0, V1, E1, 17, 0);
    do_req(2, 1'b1, KV, KE, 5, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
